// File: rtl/noc_adapter_pkg.sv
// rtl/noc_adapter_pkg.sv - shared NoC adapter flit layout, state encoding and sizes
package noc_adapter_pkg;

  localparam int VC_COUNT  = 8;
  localparam int VC_IDX_W  = 3;
  localparam int NODE_ID_W = 4;
  localparam int FLIT_W    = 32;
  localparam int RESP_W    = 2;

  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 28;
  localparam int SRC_MSB  = 27;
  localparam int SRC_LSB  = 24;
  localparam int READ_BIT = 23;
  localparam int RESP_MSB = 22;
  localparam int RESP_LSB = 21;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALLOC     = 2'd1,
    ST_SEND_HEAD = 2'd2,
    ST_SEND_BODY = 2'd3
  } pkt_state_t;

endpackage

// File: rtl/sna_flit_encoder.sv
// rtl/sna_flit_encoder.sv - combinational header/payload flit formatter
module sna_flit_encoder
  import noc_adapter_pkg::*;
(
  input  logic [NODE_ID_W-1:0] dest_id,
  input  logic [NODE_ID_W-1:0] src_id,
  input  logic                 read_flag,
  input  logic [RESP_W-1:0]    resp,
  input  logic [FLIT_W-1:0]    rdata,
  output logic [FLIT_W-1:0]    head_flit,
  output logic [FLIT_W-1:0]    body_flit
);

  always_comb begin
    head_flit                    = '0;
    head_flit[DEST_MSB:DEST_LSB] = dest_id;
    head_flit[SRC_MSB:SRC_LSB]   = src_id;
    head_flit[READ_BIT]          = read_flag;
    head_flit[RESP_MSB:RESP_LSB] = resp;
    // Write responses carry only the response code in the payload
    body_flit = read_flag ? rdata : {{(FLIT_W-RESP_W){1'b0}}, resp};
  end

endmodule

// File: rtl/sna_response_packetizer.sv
// rtl/sna_response_packetizer.sv - slave-side adapter packing AXI-Lite B/R responses into two-flit NoC packets
module sna_response_packetizer
  import noc_adapter_pkg::*;
#(
  parameter int                   VC      = 0,
  parameter logic [NODE_ID_W-1:0] SRC_ID  = '0,
  parameter logic [NODE_ID_W-1:0] DEST_ID = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bvalid,
  input  logic [RESP_W-1:0]   bresp,
  output logic                bready,
  input  logic                rvalid,
  input  logic [FLIT_W-1:0]   rdata,
  input  logic [RESP_W-1:0]   rresp,
  output logic                rready,
  input  logic [VC_COUNT-1:0] is_allocatable,
  input  logic [VC_COUNT-1:0] is_on_off,
  output logic                is_valid,
  output logic                read,
  output logic [FLIT_W-1:0]   ubdata
);

  localparam logic [VC_IDX_W-1:0] VC_SEL = VC[VC_IDX_W-1:0];

  pkt_state_t          state;
  logic                cap_read;
  logic [RESP_W-1:0]   cap_resp;
  logic [FLIT_W-1:0]   cap_rdata;
  logic [FLIT_W-1:0]   head_flit;
  logic [FLIT_W-1:0]   body_flit;
  logic                vc_alloc;
  logic                vc_on;
  logic                unused_other_vc;

  assign vc_alloc        = is_allocatable[VC_SEL];
  assign vc_on           = is_on_off[VC_SEL];
  assign unused_other_vc = ^{is_allocatable, is_on_off};

  // R has priority, so B must not see a handshake on an edge where R is taken
  assign rready = (state == ST_IDLE) && !reset;
  assign bready = (state == ST_IDLE) && !reset && !rvalid;

  sna_flit_encoder u_encoder (
    .dest_id   (DEST_ID),
    .src_id    (SRC_ID),
    .read_flag (cap_read),
    .resp      (cap_resp),
    .rdata     (cap_rdata),
    .head_flit (head_flit),
    .body_flit (body_flit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      is_valid  <= 1'b0;
      read      <= 1'b0;
      ubdata    <= '0;
      cap_read  <= 1'b0;
      cap_resp  <= '0;
      cap_rdata <= '0;
    end else begin
      is_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rvalid) begin
            cap_read  <= 1'b1;
            cap_resp  <= rresp;
            cap_rdata <= rdata;
            state     <= ST_ALLOC;
          end else if (bvalid) begin
            cap_read  <= 1'b0;
            cap_resp  <= bresp;
            state     <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (vc_alloc) state <= ST_SEND_HEAD;
        end
        ST_SEND_HEAD: begin
          if (vc_on) begin
            is_valid <= 1'b1;
            read     <= cap_read;
            ubdata   <= head_flit;
            state    <= ST_SEND_BODY;
          end
        end
        ST_SEND_BODY: begin
          if (vc_on) begin
            is_valid <= 1'b1;
            read     <= cap_read;
            ubdata   <= body_flit;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sna_response_packetizer.sv
// tb/tb_sna_response_packetizer.sv - randomized and directed bench with queue-based packet model
module tb_sna_response_packetizer;

  localparam int         VC  = 3;
  localparam logic [3:0] SRC = 4'h5;
  localparam logic [3:0] DST = 4'h3;

  logic        clock = 1'b0;
  logic        reset;
  logic        bvalid, bready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  is_allocatable, is_on_off;
  logic        is_valid, read;
  logic [31:0] ubdata;

  always #5 clock = ~clock;

  sna_response_packetizer #(.VC(VC), .SRC_ID(SRC), .DEST_ID(DST)) dut (
    .clock(clock), .reset(reset),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .is_allocatable(is_allocatable), .is_on_off(is_on_off),
    .is_valid(is_valid), .read(read), .ubdata(ubdata)
  );

  typedef struct {
    logic [31:0] data;
    logic        rd;
    int          cyc;
  } flit_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  flit_t seen[$];

  // bench-side slave and router controls
  logic        r_pend = 0, b_pend = 0, reset_ctl = 1, alloc_ctl = 1, onoff_ctl = 1;
  logic [31:0] rdata_v = 0;
  logic [1:0]  rresp_v = 0, bresp_v = 0;
  int          head_action = 0;

  // model: a packet is a queue of flits still owed, gated once by allocation
  logic [31:0] m_q[$];
  logic        m_busy = 0, m_need_alloc = 0, m_flag = 0;
  logic        e_valid = 0, e_read = 0;
  logic [31:0] e_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] hdr(input logic rd, input logic [1:0] rs);
    return ({28'b0, DST} << 28) | ({28'b0, SRC} << 24) | ({31'b0, rd} << 23) | ({30'b0, rs} << 21);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_busy = 0; m_need_alloc = 0; m_q.delete();
      e_valid = 0; e_read = 0; e_data = 0;
    end else begin
      e_valid = 0;
      if (!m_busy) begin
        if (rvalid) begin
          m_flag = 1; m_q.delete(); m_q.push_back(hdr(1'b1, rresp)); m_q.push_back(rdata);
          m_busy = 1; m_need_alloc = 1; r_pend = 0; acc_cyc = cyc;
        end else if (bvalid) begin
          m_flag = 0; m_q.delete(); m_q.push_back(hdr(1'b0, bresp)); m_q.push_back({30'b0, bresp});
          m_busy = 1; m_need_alloc = 1; b_pend = 0; acc_cyc = cyc;
        end
      end else if (m_need_alloc) begin
        if (is_allocatable[VC]) m_need_alloc = 0;
      end else if (is_on_off[VC]) begin
        e_valid = 1; e_read = m_flag; e_data = m_q.pop_front();
        if (m_q.size() == 0) m_busy = 0;
      end
    end
  endtask

  task automatic apply();
    logic [7:0] a, o;
    a = 8'($urandom); o = 8'($urandom);
    a[VC] = alloc_ctl; o[VC] = onoff_ctl;
    reset = reset_ctl; rvalid = r_pend; rdata = rdata_v; rresp = rresp_v;
    bvalid = b_pend; bresp = bresp_v; is_allocatable = a; is_on_off = o;
  endtask

  task automatic tick();
    @(negedge clock);
    chk("is_valid", 32'(is_valid), 32'(e_valid));
    chk("read", 32'(read), 32'(e_read));
    chk("ubdata", ubdata, e_data);
    if (is_valid) seen.push_back('{ubdata, read, cyc});
    if (head_action != 0 && e_valid && m_q.size() == 1) begin
      if (head_action == 1) onoff_ctl = 0;
      else reset_ctl = 1;
      head_action = 0;
    end
    apply();
    #1;
    chk("rready", 32'(rready), 32'(!reset && !m_busy));
    chk("bready", 32'(bready), 32'(!reset && !m_busy && !rvalid));
    @(posedge clock);
    cyc++;
    model_step();
  endtask

  initial begin
    apply();
    repeat (2) @(posedge clock);
    model_step();

    // reset state
    repeat (2) tick();
    #1;
    chk("reset_rready", 32'(rready), 32'd0);
    chk("reset_bready", 32'(bready), 32'd0);
    chk("reset_is_valid", 32'(is_valid), 32'd0);
    chk("reset_ubdata", ubdata, 32'd0);
    reset_ctl = 0;
    tick();
    #1;
    chk("post_reset_rready", 32'(rready), 32'd1);
    chk("post_reset_bready", 32'(bready), 32'd1);

    // read response
    seen.delete();
    r_pend = 1; rdata_v = 32'hDEADBEEF; rresp_v = 2'b00;
    repeat (6) tick();
    chk("rd_count", 32'(seen.size()), 32'd2);
    if (seen.size() >= 2) begin
      chk("rd_head", seen[0].data, 32'h3580_0000);
      chk("rd_head_read", 32'(seen[0].rd), 32'd1);
      chk("rd_body", seen[1].data, 32'hDEADBEEF);
      chk("rd_head_latency", 32'(seen[0].cyc - acc_cyc), 32'd2);
      chk("rd_back_to_back", 32'(seen[1].cyc - seen[0].cyc), 32'd1);
    end

    // write response
    seen.delete();
    b_pend = 1; bresp_v = 2'b10;
    repeat (6) tick();
    chk("wr_count", 32'(seen.size()), 32'd2);
    if (seen.size() >= 2) begin
      chk("wr_head", seen[0].data, 32'h3540_0000);
      chk("wr_head_read", 32'(seen[0].rd), 32'd0);
      chk("wr_body", seen[1].data, 32'h0000_0002);
    end

    // simultaneous R and B
    seen.delete();
    r_pend = 1; rdata_v = 32'hCAFE_0001; rresp_v = 2'b01;
    b_pend = 1; bresp_v = 2'b11;
    repeat (12) tick();
    chk("sim_count", 32'(seen.size()), 32'd4);
    if (seen.size() >= 4) begin
      chk("sim_first_head", seen[0].data, 32'h35A0_0000);
      chk("sim_first_body", seen[1].data, 32'hCAFE_0001);
      chk("sim_second_head", seen[2].data, 32'h3560_0000);
      chk("sim_second_body", seen[3].data, 32'h0000_0003);
    end

    // allocation held off
    seen.delete();
    alloc_ctl = 0; b_pend = 1; bresp_v = 2'b01;
    repeat (6) tick();
    chk("alloc_hold_none", 32'(seen.size()), 32'd0);
    alloc_ctl = 1;
    repeat (3) tick();
    chk("alloc_release_head", 32'(seen.size()), 32'd1);
    if (seen.size() >= 1) chk("alloc_head", seen[0].data, 32'h3520_0000);
    repeat (3) tick();

    // on/off drop between header and payload
    seen.delete();
    head_action = 1; r_pend = 1; rdata_v = 32'h1234_5678; rresp_v = 2'b10;
    for (int i = 0; i < 10 && head_action != 0; i++) tick();
    chk("drop_hook_fired", 32'(head_action), 32'd0);
    repeat (2) tick();
    onoff_ctl = 1;
    repeat (3) tick();
    chk("drop_count", 32'(seen.size()), 32'd2);
    if (seen.size() >= 2) begin
      chk("drop_head", seen[0].data, 32'h35C0_0000);
      chk("drop_body", seen[1].data, 32'h1234_5678);
      chk("drop_gap", 32'(seen[1].cyc - seen[0].cyc), 32'd4);
    end

    // reset while payload is owed
    seen.delete();
    head_action = 2; r_pend = 1; rdata_v = 32'h0BAD_F00D; rresp_v = 2'b00;
    for (int i = 0; i < 10 && head_action != 0; i++) tick();
    repeat (2) tick();
    reset_ctl = 0; b_pend = 1; bresp_v = 2'b00;
    repeat (8) tick();
    chk("rst_mid_count", 32'(seen.size()), 32'd3);
    if (seen.size() >= 3) begin
      chk("rst_mid_head", seen[0].data, 32'h3580_0000);
      chk("rst_mid_new_head", seen[1].data, 32'h3500_0000);
      chk("rst_mid_new_body", seen[2].data, 32'h0000_0000);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!r_pend && $urandom_range(0, 3) == 0) begin
        r_pend = 1; rdata_v = $urandom; rresp_v = 2'($urandom_range(0, 3));
      end
      if (!b_pend && $urandom_range(0, 3) == 0) begin
        b_pend = 1; bresp_v = 2'($urandom_range(0, 3));
      end
      alloc_ctl = ($urandom_range(0, 9) < 7);
      onoff_ctl = ($urandom_range(0, 9) < 7);
      reset_ctl = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset_ctl = 0; alloc_ctl = 1; onoff_ctl = 1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
